// File: rtl/control_sequencer.sv
// Control sequencer: fetches 16-bit instructions, decodes them into
// function-unit and register-file controls, and steps the program counter.
// Fetch handshake: IDATA is taken only on a rising CLK edge where the
// sequencer is in FETCH and IREADY=1. There is no back-pressure.
module control_sequencer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] IDATA,
  input  logic        IREADY,
  input  logic        V,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  output logic [7:0]  IADDR,
  output logic [3:0]  FS,
  output logic [1:0]  AA,
  output logic [1:0]  BA,
  output logic [1:0]  DA,
  output logic        MB,
  output logic [7:0]  CONST,
  output logic        RW,
  output logic [3:0]  FLAGS,
  output logic        HALT,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_WB     = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_BRZ  = 4'h4;
  localparam logic [3:0] OP_BRC  = 4'h5;
  localparam logic [3:0] OP_BRN  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  flags_q, flags_d;

  logic [3:0]  opcode;
  logic [7:0]  target;
  logic [7:0]  pc_inc;

  assign opcode = ir_q[15:12];
  assign target = ir_q[7:0];
  assign pc_inc = pc_q + 8'd1;

  // State, PC, IR and status register; all cleared asynchronously by RESET.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_FETCH;
      pc_q    <= 8'h00;
      ir_q    <= 16'h0000;
      flags_q <= 4'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  // Next-state logic: instruction fetch, execute dispatch, write-back and PC update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    unique case (state_q)
      S_FETCH: begin
        if (IREADY) begin
          ir_d    = IDATA;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_ALU: begin
            flags_d = {V, C, N, Z};
            state_d = S_WB;
          end
          OP_LDI:  state_d = S_WB;
          OP_JMP:  pc_d = target;
          // Branches test the latched status register, never the live flags.
          OP_BRZ:  pc_d = flags_q[0] ? target : pc_inc;
          OP_BRC:  pc_d = flags_q[2] ? target : pc_inc;
          OP_BRN:  pc_d = flags_q[1] ? target : pc_inc;
          OP_HALT: state_d = S_HALTED;
          default: pc_d = pc_inc;
        endcase
      end
      S_WB: begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  // Decode outputs: driven from IR only while executing or writing back.
  always_comb begin
    FS    = 4'h0;
    AA    = 2'd0;
    BA    = 2'd0;
    DA    = 2'd0;
    MB    = 1'b0;
    CONST = 8'h00;
    if (state_q == S_EXEC || state_q == S_WB) begin
      case (opcode)
        OP_ALU: begin
          FS = ir_q[11:8];
          DA = ir_q[7:6];
          AA = ir_q[5:4];
          BA = ir_q[3:2];
        end
        OP_LDI: begin
          FS    = 4'd12;
          DA    = ir_q[11:10];
          MB    = 1'b1;
          CONST = ir_q[7:0];
        end
        default: ;
      endcase
    end
  end

  // RW is gated by RESET directly so an asynchronous reset in WB kills the write at once.
  assign RW          = (state_q == S_WB) && !RESET;
  assign HALT        = (state_q == S_HALTED);
  assign IADDR       = pc_q;
  assign FLAGS       = flags_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: an instruction-level model predicts the
// full output vector for every cycle; a compare process checks each one.
module tb_control_sequencer;

  localparam int W = 33;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] IDATA = 16'h0000;
  logic        IREADY = 1'b0;
  logic        V = 1'b0, C = 1'b0, N = 1'b0, Z = 1'b0;
  logic [7:0]  IADDR;
  logic [3:0]  FS;
  logic [1:0]  AA, BA, DA;
  logic        MB;
  logic [7:0]  CONST;
  logic        RW;
  logic [3:0]  FLAGS;
  logic        HALT;
  logic [1:0]  dbg_state;

  control_sequencer dut (
    .CLK(CLK), .RESET(RESET), .IDATA(IDATA), .IREADY(IREADY),
    .V(V), .C(C), .N(N), .Z(Z),
    .IADDR(IADDR), .FS(FS), .AA(AA), .BA(BA), .DA(DA), .MB(MB),
    .CONST(CONST), .RW(RW), .FLAGS(FLAGS), .HALT(HALT),
    .dbg_state_o(dbg_state)
  );

  // Clock
  always #5 CLK = ~CLK;

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Instruction-level model state
  logic [7:0] m_pc = 8'h00;
  logic [3:0] m_flags = 4'h0;
  logic       m_halted = 1'b0;

  // Snapshots of DUT outputs for hand-computed literal checks
  logic [18:0] ex_snap;
  logic        rw_snap;

  function automatic logic [W-1:0] pack(input logic [7:0] ia, input logic [18:0] f,
                                        input logic rw, input logic [3:0] fl, input logic h);
    return {ia, f, rw, fl, h};
  endfunction

  // Decode fields {FS,AA,BA,DA,MB,CONST} an instruction shows in EXEC/WB.
  function automatic logic [18:0] decode(input logic [15:0] w);
    case (w[15:12])
      4'h1:    return {w[11:8], w[5:4], w[3:2], w[7:6], 1'b0, 8'h00};
      4'h2:    return {4'd12, 2'd0, 2'd0, w[11:10], 1'b1, w[7:0]};
      default: return 19'd0;
    endcase
  endfunction

  function automatic logic [W-1:0] idle_vec();
    return pack(m_pc, 19'd0, 1'b0, m_flags, m_halted);
  endfunction

  // Compare process: one expected vector per cycle, sampled mid-cycle.
  always @(negedge CLK) begin
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = pack(IADDR, {FS, AA, BA, DA, MB, CONST}, RW, FLAGS, HALT);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t act=%h exp=%h (iaddr,fs,aa,ba,da,mb,const,rw,flags,halt)",
                 $time, a, e);
      end
    end
  end

  // One clock cycle: drive inputs just after the edge and queue the expected outputs.
  task automatic step(input logic [W-1:0] e, input logic rdy, input logic [15:0] d,
                      input logic [3:0] vcnz, input logic rst);
    @(posedge CLK);
    #1;
    RESET  = rst;
    IREADY = rdy;
    IDATA  = d;
    {V, C, N, Z} = vcnz;
    exp_q.push_back(e);
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, got, want);
    end
  endtask

  task automatic idle_step();
    step(idle_vec(), 1'b0, 16'($urandom), 4'($urandom), 1'b0);
  endtask

  task automatic do_reset();
    m_pc = 8'h00;
    m_flags = 4'h0;
    m_halted = 1'b0;
    step(idle_vec(), 1'b0, 16'($urandom), 4'($urandom), 1'b1);
    step(idle_vec(), 1'b0, 16'($urandom), 4'($urandom), 1'b1);
    step(idle_vec(), 1'b0, 16'($urandom), 4'($urandom), 1'b0);
  endtask

  // Fetch after 'waits' idle cycles, execute, and (for ALU/LDI) write back.
  task automatic do_instr(input logic [15:0] w, input int waits, input logic [3:0] vcnz);
    logic [18:0] f;
    logic [7:0]  t;
    f = decode(w);
    t = w[7:0];
    for (int i = 0; i < waits; i++) idle_step();
    step(idle_vec(), 1'b1, w, 4'($urandom), 1'b0);
    step(pack(m_pc, f, 1'b0, m_flags, 1'b0), 1'($urandom), 16'($urandom), vcnz, 1'b0);
    #2 ex_snap = {FS, AA, BA, DA, MB, CONST};
    case (w[15:12])
      4'h1, 4'h2: begin
        if (w[15:12] == 4'h1) m_flags = vcnz;
        step(pack(m_pc, f, 1'b1, m_flags, 1'b0), 1'($urandom), 16'($urandom), 4'($urandom), 1'b0);
        #2 rw_snap = RW;
        m_pc = m_pc + 8'd1;
      end
      4'h3: m_pc = t;
      4'h4: m_pc = m_flags[0] ? t : m_pc + 8'd1;
      4'h5: m_pc = m_flags[2] ? t : m_pc + 8'd1;
      4'h6: m_pc = m_flags[1] ? t : m_pc + 8'd1;
      4'hF: m_halted = 1'b1;
      default: m_pc = m_pc + 8'd1;
    endcase
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] w;
    logic [7:0]  frozen;

    // Reset state
    do_reset();
    #2;
    lit("reset_iaddr", IADDR, 8'h00);
    lit("reset_halt", HALT, 1'b0);
    lit("reset_rw", RW, 1'b0);
    lit("reset_flags", FLAGS, 4'h0);

    // LDI 0x2A5C
    do_instr(16'h2A5C, 0, 4'h0);
    lit("ldi_exec_fields", ex_snap, {4'd12, 2'd0, 2'd0, 2'd2, 1'b1, 8'h5C});
    lit("ldi_rw", rw_snap, 1'b1);
    idle_step();
    #2 lit("ldi_pc", IADDR, 8'h01);

    // ALU 0x1294 with Z=1, C=1
    do_instr(16'h1294, 1, 4'b0101);
    lit("alu_exec_fields", ex_snap, {4'd2, 2'd1, 2'd1, 2'd2, 1'b0, 8'h00});
    lit("alu_rw", rw_snap, 1'b1);
    idle_step();
    #2 lit("alu_flags", FLAGS, 4'b0101);

    // BRZ taken, then not taken after an ALU clears Z
    do_instr(16'h4033, 0, 4'hF);
    idle_step();
    #2 lit("brz_taken", IADDR, 8'h33);
    do_instr(16'h1000, 0, 4'b0000);
    do_instr(16'h4077, 0, 4'hF);
    idle_step();
    #2 lit("brz_not_taken", IADDR, 8'h35);

    // PC wrap: JMP 0xFF, then NOP
    do_instr(16'h30FF, 0, 4'h0);
    do_instr(16'h0000, 0, 4'h0);
    idle_step();
    #2 lit("pc_wrap", IADDR, 8'h00);

    // Fetch stall of 5 cycles
    do_instr(16'h2155, 5, 4'h0);

    // Randomized instruction stream (no HALT)
    for (int k = 0; k < 300; k++) begin
      w = 16'($urandom);
      w[15:12] = 4'($urandom_range(0, 14));
      do_instr(w, $urandom_range(0, 3), 4'($urandom_range(0, 15)));
    end

    // Reset asserted in the WB cycle: the write must vanish at once
    w = 16'($urandom);
    w[15:12] = 4'h1;
    step(idle_vec(), 1'b1, w, 4'($urandom), 1'b0);
    step(pack(m_pc, decode(w), 1'b0, m_flags, 1'b0), 1'b0, 16'h0, 4'($urandom), 1'b0);
    m_pc = 8'h00;
    m_flags = 4'h0;
    step(idle_vec(), 1'b0, 16'h0, 4'($urandom), 1'b1);
    #2 lit("wb_reset_rw", RW, 1'b0);
    step(idle_vec(), 1'b0, 16'h0, 4'($urandom), 1'b0);

    // HALT: IADDR frozen for 10 cycles, then released by reset
    do_instr(16'h1000, 0, 4'($urandom));
    frozen = m_pc;
    do_instr(16'hF123, 1, 4'h0);
    for (int i = 0; i < 10; i++)
      step(idle_vec(), 1'($urandom), 16'($urandom), 4'($urandom), 1'b0);
    #2;
    lit("halt_flag", HALT, 1'b1);
    lit("halt_iaddr", IADDR, frozen);
    do_reset();
    #2;
    lit("post_halt_reset_halt", HALT, 1'b0);
    lit("post_halt_reset_iaddr", IADDR, 8'h00);

    // Drain the scoreboard
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have the port CLK, input, 1 bit: the single system clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port IDATA, input, 16 bits: the instruction word from instruction memory at address IADDR.
REQ-004 The block SHALL have the port IREADY, input, 1 bit: IDATA is valid this cycle.
REQ-005 The block SHALL have the ports V, C, N, Z, input, 1 bit each: function-unit flags, combinational from the current FS/operands.
REQ-006 The block SHALL have the port IADDR, output, 8 bits: the program counter (PC).
REQ-007 The block SHALL have the port FS, output, 4 bits: the function-unit operation select.
REQ-008 The block SHALL have the ports AA, BA, DA, output, 2 bits each: the register-file A-read, B-read and destination addresses.
REQ-009 The block SHALL have the port MB, output, 1 bit: BBUS source select (1 = CONST, 0 = register B).
REQ-010 The block SHALL have the port CONST, output, 8 bits: the immediate value.
REQ-011 The block SHALL have the port RW, output, 1 bit: register-file write strobe; the function-unit result is written to DA.
REQ-012 The block SHALL have the port FLAGS, output, 4 bits: the status register {V,C,N,Z}.
REQ-013 The block SHALL have the port HALT, output, 1 bit: the sequencer is halted.

Function
REQ-014 The instruction register IR SHALL be 16 bits, with opcode = IR[15:12].
- 0x1 ALU: FS=IR[11:8], DA=IR[7:6], AA=IR[5:4], BA=IR[3:2].
- 0x2 LDI: DA=IR[11:10], CONST=IR[7:0], MB=1, FS=12.
- 0x3 JMP, 0x4 BRZ, 0x5 BRC, 0x6 BRN: target=IR[7:0].
- 0xF HALT.
- All other opcodes: NOP.
REQ-015 The FSM states SHALL be FETCH, EXEC, WB and HALTED.
REQ-016 In FETCH, the block SHALL wait while IREADY=0; when IREADY=1, it SHALL load IR<=IDATA and go to EXEC.
REQ-017 In EXEC, the block SHALL drive FS/AA/BA/DA/MB/CONST decoded from IR; RW SHALL be 0.
REQ-018 For ALU, at the end of EXEC the block SHALL load FLAGS<={V,C,N,Z} and go to WB.
REQ-019 For LDI, at the end of EXEC the block SHALL go to WB without changing FLAGS.
REQ-020 In WB, the block SHALL hold the EXEC decode, drive RW=1 for exactly one cycle, set PC<=PC+1, and go to FETCH.
REQ-021 For JMP, at the end of EXEC the block SHALL set PC<=target and go to FETCH.
REQ-022 For BRZ/BRC/BRN, at the end of EXEC the block SHALL set PC<=target if FLAGS[0]/FLAGS[2]/FLAGS[1] respectively is 1, else PC<=PC+1, then go to FETCH; the condition SHALL use latched FLAGS, not live flag inputs.
REQ-023 For NOP, at the end of EXEC the block SHALL set PC<=PC+1 and go to FETCH.
REQ-024 For HALT, at the end of EXEC the block SHALL go to HALTED with PC unchanged; HALTED SHALL be exited only by RESET, and in HALTED HALT=1.
REQ-025 Latency from FETCH entry with IREADY=1 SHALL be 3 cycles for ALU/LDI and 2 cycles for jump/branch/NOP.
REQ-026 PC arithmetic SHALL be 8-bit modulo, so 0xFF+1 yields 0x00.
REQ-027 Outside EXEC/WB, FS, AA, BA, DA, MB and CONST SHALL be 0.
REQ-028 RW SHALL be 1 only in WB.
REQ-029 FLAGS SHALL change only at the end of EXEC of an ALU instruction.

Reset
REQ-030 While RESET=1, regardless of state, the block SHALL hold PC=0, IR=0, FLAGS=0, state=FETCH, HALT=0, RW=0, MB=0, FS=0, AA=BA=DA=0 and CONST=0.
REQ-031 Release of RESET SHALL start FETCH of address 0x00 on the next rising CLK edge.
REQ-032 RESET asserted during WB SHALL suppress RW immediately, so that no write occurs.

Verification
REQ-033 Reset, then IDATA=0x2A5C (LDI) with IREADY=1 -> EXEC shows FS=12, MB=1, CONST=0x5C, DA=2; next cycle RW=1 for one cycle; IADDR=0x01.
REQ-034 ALU 0x1294 with Z=1, C=1 at EXEC -> FS=2, DA=2, AA=1, BA=1; FLAGS=4'b0101 after EXEC; RW pulses in WB.
REQ-035 FLAGS[0]=1, BRZ 0x4033 -> IADDR=0x33 two cycles after fetch; with FLAGS[0]=0 -> IADDR=PC+1.
REQ-036 PC=0xFF executing NOP 0x0000 -> IADDR=0x00.
REQ-037 IREADY held 0 for 5 cycles in FETCH -> IR, PC and state unchanged and RW=0.
REQ-038 Opcode 0xF -> HALT=1, IADDR frozen for 10 cycles; RESET pulse -> HALT=0, IADDR=0x00.
